// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Multi-cycle sequencer that drives a shared combinational 8-bit ALU to run
// 16-bit operations on behalf of the decode/execute stage:
//   op = 0 : unsigned 8x8 -> 16 multiply (shift-and-add, 8 ALU passes)
//   op = 1 : 16-bit add (low byte, high byte, then carry fold-in)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request and operation select (sampled only when idle)
//   opa, opb          16-bit operands (MUL uses the low bytes only)
//   result, carry     registered result, held until the next operation ends
//   busy, done        busy while in flight; done pulses for one cycle
//   alu_rs1, alu_rs2  ALU operand drive
//   alu_ctrl          ALU function select, constant add
//   alu_flag          ALU add/sub flag, constant add
//   alu_out, alu_ovf  ALU sum and carry-out, combinational from the drive
// -----------------------------------------------------------------------------
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic [15:0] result,
  output logic        carry,
  output logic        busy,
  output logic        done,
  output logic [7:0]  alu_rs1,
  output logic [7:0]  alu_rs2,
  output logic [2:0]  alu_ctrl,
  output logic        alu_flag,
  input  logic [7:0]  alu_out,
  input  logic        alu_ovf
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_ADD_LO = 3'd2,
    S_ADD_HI = 3'd3,
    S_ADD_C  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;

  // Latched operands; changes on opa/opb while busy are invisible.
  logic [15:0] a_r;
  logic [15:0] b_r;

  // Multiply datapath: hi_r is the running upper half, mq_r holds the
  // not-yet-consumed multiplier bits and collects the product low bits.
  logic [2:0]  cnt_r;
  logic [7:0]  hi_r;
  logic [7:0]  mq_r;

  // ADD16 partial results.
  logic [7:0]  lo_r;
  logic [7:0]  hs_r;
  logic        c0_r;
  logic        c1_r;

  logic [15:0] result_r;
  logic        carry_r;
  logic        busy_r;
  logic        done_r;
  logic        busy_s;
  logic        done_s;

  logic [7:0]  rs1_s;
  logic [7:0]  rs2_s;

  // Next-state selection and ALU operand drive for the current state.
  always_comb begin
    state_s = state_r;
    rs1_s   = 8'h00;
    rs2_s   = 8'h00;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = op ? S_ADD_LO : S_MUL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL: begin
        rs1_s = hi_r;
        // Add the multiplicand only when the current multiplier bit is set.
        if (mq_r[0]) begin
          rs2_s = a_r[7:0];
        end else begin
          rs2_s = 8'h00;
        end
        if (cnt_r == 3'd7) begin
          state_s = S_DONE;
        end else begin
          state_s = S_MUL;
        end
      end
      S_ADD_LO: begin
        rs1_s   = a_r[7:0];
        rs2_s   = b_r[7:0];
        state_s = S_ADD_HI;
      end
      S_ADD_HI: begin
        rs1_s   = a_r[15:8];
        rs2_s   = b_r[15:8];
        state_s = S_ADD_C;
      end
      S_ADD_C: begin
        rs1_s   = hs_r;
        rs2_s   = {7'b0000000, c0_r};
        state_s = S_DONE;
      end
      S_DONE: begin
        // start is deliberately not looked at here.
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Handshake flags derived from the state being entered, so they are registered.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      S_MUL, S_ADD_LO, S_ADD_HI, S_ADD_C: busy_s = 1'b1;
      S_DONE:                              done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 16'h0000;
      b_r <= 16'h0000;
    end else if ((state_r == S_IDLE) && start) begin
      a_r <= opa;
      b_r <= opb;
    end
  end

  // Shift-and-add multiply datapath: the 9-bit ALU sum is shifted right one
  // place across hi_r and mq_r each pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 3'd0;
      hi_r  <= 8'h00;
      mq_r  <= 8'h00;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cnt_r <= 3'd0;
            hi_r  <= 8'h00;
            mq_r  <= opb[7:0];
          end
        end
        S_MUL: begin
          cnt_r <= cnt_r + 3'd1;
          hi_r  <= {alu_ovf, alu_out[7:1]};
          mq_r  <= {alu_out[0], mq_r[7:1]};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // ADD16 partial sums and their carries; carries clear on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r <= 8'h00;
      hs_r <= 8'h00;
      c0_r <= 1'b0;
      c1_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            c0_r <= 1'b0;
            c1_r <= 1'b0;
          end
        end
        S_ADD_LO: begin
          lo_r <= alu_out;
          c0_r <= alu_ovf;
        end
        S_ADD_HI: begin
          hs_r <= alu_out;
          c1_r <= alu_ovf;
        end
        default: begin
          lo_r <= lo_r;
        end
      endcase
    end
  end

  // Result capture on the final compute edge; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 16'h0000;
      carry_r  <= 1'b0;
    end else begin
      case (state_r)
        S_MUL: begin
          if (cnt_r == 3'd7) begin
            // Same values hi_r/mq_r are about to take on this edge.
            result_r <= {alu_ovf, alu_out, mq_r[7:1]};
            carry_r  <= 1'b0;
          end
        end
        S_ADD_C: begin
          result_r <= {alu_out, lo_r};
          // A high-byte overflow and a fold-in overflow are mutually exclusive.
          carry_r  <= c1_r | alu_ovf;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  assign result   = result_r;
  assign carry    = carry_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign alu_rs1  = rs1_s;
  assign alu_rs2  = rs2_s;
  assign alu_ctrl = 3'b000;
  assign alu_flag = 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Directed bench for alu_seq. A behavioural 8-bit ALU adder stands in for the
// real ALU instance. Vectors are table-driven; reset-abort and back-to-back
// sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] result;
  logic        carry;
  logic        busy;
  logic        done;
  logic [7:0]  alu_rs1;
  logic [7:0]  alu_rs2;
  logic [2:0]  alu_ctrl;
  logic        alu_flag;
  logic [7:0]  alu_out;
  logic        alu_ovf;

  int          pass_cnt;
  int          tot_cnt;
  logic [15:0] exp_prev;

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cy;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  alu_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .result   (result),
    .carry    (carry),
    .busy     (busy),
    .done     (done),
    .alu_rs1  (alu_rs1),
    .alu_rs2  (alu_rs2),
    .alu_ctrl (alu_ctrl),
    .alu_flag (alu_flag),
    .alu_out  (alu_out),
    .alu_ovf  (alu_ovf)
  );

  // Behavioural ALU: 8-bit add with carry-out.
  assign {alu_ovf, alu_out} = {1'b0, alu_rs1} + {1'b0, alu_rs2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Issues one operation, scrambles the
  // operands once accepted, pulses start mid-operation (unless hold), and
  // checks latency, result, carry and handshake behaviour.
  task automatic run_op(input string name, input logic o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ec,
                        input int lat, input logic hold);
    int k;
    int bad;
    bit seen;
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    opa = ~a;
    opb = ~b;
    if (!hold) start = 1'b0;
    bad  = 0;
    seen = 1'b0;
    k    = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (busy && done) bad++;
      if (done) begin
        seen = 1'b1;
        k    = c;
      end else begin
        if (!busy) bad++;
        if (alu_ctrl !== 3'b000 || alu_flag !== 1'b0) bad++;
        if (result !== exp_prev) bad++;
        if (!hold) start = (c == 2);
      end
    end
    check({name, " latency"}, k, lat);
    check({name, " result"}, {16'h0000, result}, {16'h0000, er});
    check({name, " carry"}, {31'd0, carry}, {31'd0, ec});
    check({name, " handshake"}, bad, 0);
    exp_prev = er;
    @(negedge clk);
    check({name, " idle after done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    exp_prev = 16'h0000;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    opa      = 16'h0000;
    opb      = 16'h0000;

    vecs[0] = '{"mul_ff_ff",   1'b0, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 9};
    vecs[1] = '{"mul_upper",   1'b0, 16'hAB0D, 16'hCD0B, 16'h008F, 1'b0, 9};
    vecs[2] = '{"mul_zero",    1'b0, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 9};
    vecs[3] = '{"mul_80_02",   1'b0, 16'h0080, 16'h0002, 16'h0100, 1'b0, 9};
    vecs[4] = '{"add_12ff",    1'b1, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 4};
    vecs[5] = '{"add_ffff",    1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4};
    vecs[6] = '{"add_80ff",    1'b1, 16'h80FF, 16'h8001, 16'h0100, 1'b1, 4};

    repeat (2) @(negedge clk);
    check("reset result", {16'h0000, result}, 32'd0);
    check("reset flags", {29'd0, carry, busy, done}, 32'd0);
    check("reset alu drive", {16'h0000, alu_rs1, alu_rs2}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].cy, vecs[i].lat, 1'b0);
    end

    // Back-to-back with start held high and op alternating.
    run_op("b2b_add0", 1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b0, 4, 1'b1);
    run_op("b2b_mul1", 1'b0, 16'h0007, 16'h0006, 16'h002A, 1'b0, 9, 1'b1);
    run_op("b2b_add2", 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4, 1'b1);
    run_op("b2b_mul3", 1'b0, 16'h00FF, 16'h0001, 16'h00FF, 1'b0, 9, 1'b1);
    start = 1'b0;
    @(negedge clk);

    // Reset in cycle 4 of a multiply aborts it and clears everything at once.
    start = 1'b1;
    op    = 1'b0;
    opa   = 16'h00F0;
    opb   = 16'h000F;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset result", {16'h0000, result}, 32'd0);
    check("midreset flags", {29'd0, carry, busy, done}, 32'd0);
    check("midreset alu drive", {16'h0000, alu_rs1, alu_rs2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_prev = 16'h0000;
    run_op("mul_3x5", 1'b0, 16'h0003, 16'h0005, 16'h000F, 1'b0, 9, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
